crc16_frame_arbiter: RTL and testbench
======================================

CRC16_FRAME_ARBITER -- requirements
Module: crc16_frame_arbiter

Interface
REQ-001 The block SHALL have a single clock `clk` and an asynchronous, active-high reset `rst`.
REQ-002 The block SHALL have the following parameter:
- TIMEOUT_CYC, default 255, range 1..65535: stall limit in cycles (used only under CRC16_ARB_TIMEOUT_EN).
REQ-003 The block SHALL have the following ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: async active-high reset.
- req_valid, in, 2: byte valid, one bit per requester.
- req_data, in, 16: byte per requester; [7:0] is req0, [15:8] is req1.
- req_last, in, 2: last byte of frame, per requester.
- req_ready, out, 2: byte accepted when valid&ready.
- crc_valid, out, 1: result available.
- crc_data, out, 16: CRC result.
- crc_id, out, 1: requester that owns the result.
- crc_abort, out, 1: result is a timed-out partial.
- crc_ready, in, 1: result consumer ready.

Function
REQ-004 The CRC SHALL be: polynomial 0x8005, init 0x0000, MSB-first, no reflection, no final XOR, one full byte per accepted cycle.
REQ-005 The FSM SHALL have states IDLE, BUSY and RESULT.
REQ-006 In IDLE: if any req_valid is 1, the block SHALL grant one requester, load the CRC with 0x0000 and go to BUSY next cycle; req_ready SHALL be 00 in IDLE.
REQ-007 Arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins; after reset, req0 wins.
REQ-008 In BUSY: req_ready SHALL equal the one-hot grant; an accepted byte SHALL update the CRC that cycle; req_valid low SHALL hold state.
REQ-009 In BUSY, an accepted byte with req_last=1 SHALL move the FSM to RESULT; crc_valid SHALL rise exactly 1 cycle after that acceptance.
REQ-010 In RESULT: crc_valid=1 and crc_data/crc_id/crc_abort SHALL stay stable until crc_ready=1; on handshake, go to IDLE and update the round-robin pointer; req_ready=00.
REQ-011 Frames of 1 byte and frames of unbounded length SHALL be legal; req_last on a non-accepted cycle SHALL be ignored.
REQ-012 Inputs of the non-granted requester SHALL be ignored; its pending req_valid SHALL be served next (no starvation).
REQ-013 Minimum frame overhead SHALL be 1 grant cycle plus 1 result cycle (back-to-back frames: IDLE at least 1 cycle).

Reset
REQ-014 While rst=1, the block SHALL be in IDLE with: CRC 0x0000, rr pointer at req0, req_ready=00, crc_valid=0, crc_data=0x0000, crc_id=0, crc_abort=0, timeout counter 0.
REQ-015 Reset asserted mid-frame or in RESULT SHALL discard the frame or result immediately.

Configuration
REQ-016 The feature SHALL be selected by macro CRC16_ARB_TIMEOUT_EN.
- With CRC16_ARB_TIMEOUT_EN defined: a counter SHALL count consecutive BUSY cycles with no accepted byte, and SHALL clear on each acceptance.
- On reaching TIMEOUT_CYC, the FSM SHALL go to RESULT with crc_abort=1 and crc_data holding the partial CRC.
- Without the macro: no counter SHALL exist, crc_abort SHALL be constant 0, and BUSY SHALL wait indefinitely.

Structure
REQ-017 Package crc16_pkg SHALL hold CRC16_POLY (16'h8005), CRC16_INIT (16'h0000), the state enum and the function crc16_next_byte(crc, byte).
REQ-018 Sub-module crc16_byte_engine SHALL hold the CRC register, with inputs clear, en and byte, and output crc; the arbiter SHALL hold FSM, grant, rr pointer and timeout logic.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- req0 sends ASCII "123456789" (9 bytes, last on '9'): crc_data=0xFEE8, crc_id=0, crc_valid 1 cycle after the '9' acceptance.
- req1 sends single byte 0x01 with last: crc_data=0x8005, crc_id=1.
- Both requesters assert valid together after reset, 2-byte frames each: req0 served fully first, then req1; req_ready[1]=0 throughout req0's frame.
- crc_ready held 0 for 5 cycles in RESULT: crc_valid/crc_data/crc_id stable; IDLE 1 cycle after crc_ready=1.
- rst pulsed after 3 of 9 bytes: all outputs at reset values next cycle; the rerun frame gives 0xFEE8.
- With CRC16_ARB_TIMEOUT_EN, TIMEOUT_CYC=4: after 0x01 is accepted without last, valid low 4 cycles gives crc_valid=1, crc_abort=1, crc_data=0x8005; without the macro, no result.

Source files
------------

// File: rtl/crc16_pkg.sv
// Shared definitions for the CRC-16 frame arbiter: polynomial, init value,
// FSM state type and the byte-wide CRC update.
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        RESULT = 2'd2
    } state_t;

    // MSB-first, unreflected: the byte enters the top of the register, then
    // eight shift/conditional-XOR steps.
    function automatic logic [15:0] crc16_next_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) begin
                c = {c[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_frame_arbiter_if.sv
// Requester byte streams and CRC result channel of the CRC-16 frame arbiter.
interface crc16_frame_arbiter_if;
    import crc16_pkg::*;

    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        crc_valid;
    logic [15:0] crc_data;
    logic        crc_id;
    logic        crc_abort;
    logic        crc_ready;

    modport master (
        output req_valid, req_data, req_last, crc_ready,
        input  req_ready, crc_valid, crc_data, crc_id, crc_abort
    );

    modport slave (
        input  req_valid, req_data, req_last, crc_ready,
        output req_ready, crc_valid, crc_data, crc_id, crc_abort
    );

endinterface

// File: rtl/crc16_byte_engine.sv
// CRC-16 register: cleared to the init value at frame start, advanced by one
// full byte on each enabled cycle.
module crc16_byte_engine
    import crc16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc16_next_byte(crc, data);
        end
    end

endmodule

// File: rtl/crc16_frame_arbiter.sv
// Two-requester round-robin arbiter computing CRC-16/0x8005 per frame.
// Optional stall timeout selected by macro CRC16_ARB_TIMEOUT_EN.
module crc16_frame_arbiter
    import crc16_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic                  clk,
    input logic                  rst,
    crc16_frame_arbiter_if.slave bus
);

    state_t      state;
    logic        gnt;
    logic        rr;
    logic [1:0]  ready_r;
    logic        valid_r;
    logic        id_r;
    logic        acc;
    logic        sel_last;
    logic        to_hit;
    logic        pick;
    logic        eng_clear;
    logic [7:0]  sel_byte;
    logic [15:0] crc;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC out of range 1..65535");
    end

    // ready_r is one-hot only in BUSY, so this is the acceptance strobe.
    assign acc       = |(ready_r & bus.req_valid);
    assign sel_byte  = gnt ? bus.req_data[15:8] : bus.req_data[7:0];
    assign sel_last  = bus.req_last[gnt];
    assign eng_clear = (state == IDLE) && (|bus.req_valid);

    // rr names the requester that wins a tie.
    always_comb begin
        pick = rr;
        if (bus.req_valid == 2'b01) begin
            pick = 1'b0;
        end else if (bus.req_valid == 2'b10) begin
            pick = 1'b1;
        end
    end

    crc16_byte_engine u_engine (
        .clk   (clk),
        .rst   (rst),
        .clear (eng_clear),
        .en    (acc),
        .data  (sel_byte),
        .crc   (crc)
    );

`ifdef CRC16_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        abort_r;

    assign to_hit = (state == BUSY) && !acc && (to_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            abort_r <= 1'b0;
        end else begin
            if (state != BUSY || acc || to_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (to_hit) begin
                abort_r <= 1'b1;
            end else if (state == RESULT && bus.crc_ready) begin
                abort_r <= 1'b0;
            end
        end
    end

    assign bus.crc_abort = abort_r;
`else
    assign to_hit        = 1'b0;
    assign bus.crc_abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            rr      <= 1'b0;
            ready_r <= 2'b00;
            valid_r <= 1'b0;
            id_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        gnt     <= pick;
                        ready_r <= pick ? 2'b10 : 2'b01;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if ((acc && sel_last) || to_hit) begin
                        ready_r <= 2'b00;
                        valid_r <= 1'b1;
                        id_r    <= gnt;
                        state   <= RESULT;
                    end
                end
                RESULT: begin
                    // Result held stable until the consumer takes it.
                    if (bus.crc_ready) begin
                        valid_r <= 1'b0;
                        id_r    <= 1'b0;
                        rr      <= ~gnt;
                        state   <= IDLE;
                    end
                end
                default: begin
                    ready_r <= 2'b00;
                    valid_r <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.crc_valid = valid_r;
    assign bus.crc_id    = id_r;
    assign bus.crc_data  = crc;

endmodule

// File: tb/tb_crc16_frame_arbiter.sv
// Directed scoreboard bench for crc16_frame_arbiter (optionally built with CRC16_ARB_TIMEOUT_EN).
module tb_crc16_frame_arbiter;

    localparam int TO     = 4;
    localparam int BUDGET = 400;

    typedef struct packed {
        logic [15:0] crc;
        logic        id;
        logic        abort;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    res_t       exp_q[$];
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] m[$];

    always #5 clk = ~clk;

    crc16_frame_arbiter_if bus();

    crc16_frame_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Bit-serial reference LFSR over the whole message.
    function automatic logic [15:0] model_crc(input logic [7:0] msg[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        foreach (msg[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ msg[i][k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    task automatic add_frame(input int r, input logic [7:0] msg[$], input logic [15:0] want);
        res_t e;
        for (int i = 0; i < msg.size(); i++) begin
            if (r == 0) q0.push_back({(i == msg.size() - 1), msg[i]});
            else        q1.push_back({(i == msg.size() - 1), msg[i]});
        end
        e.crc   = want;
        e.id    = 1'(r);
        e.abort = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic run(input int first, input int hold, input int max_acc);
        int          cyc;
        int          held;
        int          accs;
        logic [1:0]  v;
        logic [1:0]  rdy;
        logic        cv;
        logic [15:0] cd;
        logic        ci;
        logic        ca;
        logic [15:0] sd;
        logic        si;
        logic        last_acc;
        logic [8:0]  tmp;
        res_t        e;
        cyc  = 0;
        held = 0;
        accs = 0;
        sd   = '0;
        si   = 1'b0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && cyc < BUDGET &&
               (max_acc < 0 || accs < max_acc)) begin
            v = {q1.size() > 0, q0.size() > 0};
            bus.req_valid = v;
            bus.req_data  = {(v[1] ? q1[0][7:0] : 8'h00), (v[0] ? q0[0][7:0] : 8'h00)};
            bus.req_last  = {(v[1] ? q1[0][8] : 1'b0), (v[0] ? q0[0][8] : 1'b0)};
            cv = bus.crc_valid;
            cd = bus.crc_data;
            ci = bus.crc_id;
            ca = bus.crc_abort;
            bus.crc_ready = !(cv && held < hold);
            rdy = bus.req_ready;
            if (first == 0 && q0.size() > 0) chk("r1_blocked", 32'(rdy[1]), 32'd0);
            if (first == 1 && q1.size() > 0) chk("r0_blocked", 32'(rdy[0]), 32'd0);
            @(posedge clk);
            #1;
            cyc++;
            last_acc = 1'b0;
            if (rdy[0] && v[0]) begin
                last_acc = last_acc | q0[0][8];
                tmp = q0.pop_front();
                accs++;
            end
            if (rdy[1] && v[1]) begin
                last_acc = last_acc | q1[0][8];
                tmp = q1.pop_front();
                accs++;
            end
            if (last_acc) chk("valid_after_last", 32'(bus.crc_valid), 32'd1);
            if (cv && bus.crc_ready) begin
                chk("result_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("crc_data", 32'(cd), 32'(e.crc));
                    chk("crc_id", 32'(ci), 32'(e.id));
                    chk("crc_abort", 32'(ca), 32'(e.abort));
                end
                chk("idle_after_hs", 32'(bus.crc_valid), 32'd0);
                held = 0;
            end else if (cv) begin
                if (held == 0) begin
                    sd = cd;
                    si = ci;
                end
                held++;
                chk("hold_valid", 32'(bus.crc_valid), 32'd1);
                chk("hold_data", 32'(bus.crc_data), 32'(sd));
                chk("hold_id", 32'(bus.crc_id), 32'(si));
            end
        end
        bus.req_valid = 2'b00;
        bus.req_last  = 2'b00;
        bus.crc_ready = 1'b1;
        chk("run_budget", 32'(cyc < BUDGET), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_crc_valid"}, 32'(bus.crc_valid), 32'd0);
        chk({tag, "_crc_data"}, 32'(bus.crc_data), 32'd0);
        chk({tag, "_crc_id"}, 32'(bus.crc_id), 32'd0);
        chk({tag, "_crc_abort"}, 32'(bus.crc_abort), 32'd0);
    endtask

    initial begin
        string s;
        s = "123456789";
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_data  = 16'h0000;
        bus.req_last  = 2'b00;
        bus.crc_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Simultaneous 2-byte frames straight after reset: req0 first.
        m.delete(); m.push_back(8'hA5); m.push_back(8'h3C);
        add_frame(0, m, model_crc(m));
        m.delete(); m.push_back(8'h00); m.push_back(8'hFF);
        add_frame(1, m, model_crc(m));
        run(0, 0, -1);

        // Check string on req0 with the consumer stalling 5 cycles.
        m.delete();
        for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
        add_frame(0, m, 16'hFEE8);
        run(-1, 5, -1);

        // req0 was served last, so req1 wins the next tie.
        m.delete(); m.push_back(8'h12); m.push_back(8'h34);
        add_frame(1, m, model_crc(m));
        m.delete(); m.push_back(8'h80); m.push_back(8'h01);
        add_frame(0, m, model_crc(m));
        run(1, 0, -1);

        // Single-byte frame on req1.
        m.delete(); m.push_back(8'h01);
        add_frame(1, m, 16'h8005);
        run(-1, 0, -1);

        // Reset after 3 of 9 bytes, then rerun the frame.
        m.delete();
        for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
        add_frame(0, m, 16'hFEE8);
        run(-1, 0, 3);
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        chk_reset_outputs("mid_rst");
        rst = 1'b0;
        q0.delete();
        q1.delete();
        exp_q.delete();
        add_frame(0, m, 16'hFEE8);
        run(-1, 0, -1);

        // Stall after one non-last byte.
        q0.push_back({1'b0, 8'h01});
        run(-1, 0, -1);
        for (int i = 1; i <= TO; i++) begin
            @(posedge clk);
            #1;
            if (i < TO) chk("stall_no_result", 32'(bus.crc_valid), 32'd0);
        end
`ifdef CRC16_ARB_TIMEOUT_EN
        chk("timeout_valid", 32'(bus.crc_valid), 32'd1);
        chk("timeout_abort", 32'(bus.crc_abort), 32'd1);
        begin
            res_t e;
            e.crc   = 16'h8005;
            e.id    = 1'b0;
            e.abort = 1'b1;
            exp_q.push_back(e);
        end
        run(-1, 0, -1);
        chk("abort_cleared", 32'(bus.crc_abort), 32'd0);
`else
        chk("no_timeout_valid", 32'(bus.crc_valid), 32'd0);
        chk("no_timeout_abort", 32'(bus.crc_abort), 32'd0);
        chk("still_busy_ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("final_rst");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
